// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic {
    StIdle,
    StClear
  } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// Combinational read port: register mux, register-0 masking and optional write-through
// forwarding (enabled by defining REGFILE_BYPASS_EN).
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [WIDTH-1:0]  regs_i [2**ADDR_W],
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              fwd_en_i,
  input  logic              wen_a_i,
  input  logic [ADDR_W-1:0] waddr_a_i,
  input  logic [WIDTH-1:0]  wdata_a_i,
  input  logic              wen_b_i,
  input  logic [ADDR_W-1:0] waddr_b_i,
  input  logic [WIDTH-1:0]  wdata_b_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic zero_hit;
  assign zero_hit = ZERO_REG && (raddr_i == '0);

`ifdef REGFILE_BYPASS_EN
  // Port B applied first so port A overrides it when both match.
  always_comb begin
    rdata_o = regs_i[raddr_i];
    if (fwd_en_i && wen_b_i && (waddr_b_i == raddr_i)) rdata_o = wdata_b_i;
    if (fwd_en_i && wen_a_i && (waddr_a_i == raddr_i)) rdata_o = wdata_a_i;
    if (zero_hit) rdata_o = '0;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_en_i, wen_a_i, waddr_a_i, wdata_a_i, wen_b_i, waddr_b_i, wdata_b_i};

  always_comb begin
    rdata_o = zero_hit ? '0 : regs_i[raddr_i];
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Two-read/two-write register file with async reset and a sequenced bulk-clear sweep.
// Optional write-through forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic [ADDR_W-1:0] WriteRegisterA,
  input  logic [WIDTH-1:0]  WriteDataA,
  input  logic              RegWriteA,
  input  logic [ADDR_W-1:0] WriteRegisterB,
  input  logic [WIDTH-1:0]  WriteDataB,
  input  logic              RegWriteB,
  input  logic              Clear,
  output logic              Busy,
  output logic              WriteDropped
);

  localparam int unsigned       Depth    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  regs_q [Depth];
  logic [WIDTH-1:0]  regs_d [Depth];
  logic              drop_q, drop_d;
  logic              idle;
  logic              wr_a, wr_b;

  assign idle = (state_q == StIdle);
  // Writes to a hardwired register 0 vanish without being counted as drops.
  assign wr_a = RegWriteA && !(ZERO_REG && (WriteRegisterA == '0));
  assign wr_b = RegWriteB && !(ZERO_REG && (WriteRegisterB == '0));

  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (wr_b) regs_d[WriteRegisterB] = WriteDataB;
        if (wr_a) regs_d[WriteRegisterA] = WriteDataA;
        drop_d = wr_a && wr_b && (WriteRegisterA == WriteRegisterB);
        if (Clear) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + ADDR_W'(1);
        drop_d        = RegWriteA || RegWriteB;
        if (cnt_q == LastAddr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      regs_q  <= '{default: '0};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      drop_q  <= drop_d;
    end
  end

  assign Busy         = (state_q == StClear);
  assign WriteDropped = drop_q;

  regfile_rdport #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rd1 (
    .regs_i   (regs_q),
    .raddr_i  (ReadRegister1),
    .fwd_en_i (idle),
    .wen_a_i  (RegWriteA),
    .waddr_a_i(WriteRegisterA),
    .wdata_a_i(WriteDataA),
    .wen_b_i  (RegWriteB),
    .waddr_b_i(WriteRegisterB),
    .wdata_b_i(WriteDataB),
    .rdata_o  (ReadData1)
  );

  regfile_rdport #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rd2 (
    .regs_i   (regs_q),
    .raddr_i  (ReadRegister2),
    .fwd_en_i (idle),
    .wen_a_i  (RegWriteA),
    .waddr_a_i(WriteRegisterA),
    .wdata_a_i(WriteDataA),
    .wen_b_i  (RegWriteB),
    .waddr_b_i(WriteRegisterB),
    .wdata_b_i(WriteDataB),
    .rdata_o  (ReadData2)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: two DUTs (ZERO_REG=1 and ZERO_REG=0) share stimulus and are compared
// against an array model; vector table plus directed clear/reset/forwarding sequences.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rr1, rr2, waA, waB;
  logic [W-1:0]  wdA, wdB;
  logic          weA, weB, clr;
  logic [W-1:0]  rd1_z, rd2_z, rd1_n, rd2_n;
  logic          busy_z, drop_z, busy_n, drop_n;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0 instance.
  logic [W-1:0] m [2][N];
  bit           busy_m;
  int           idx_m;
  bit           drop_m [2];

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b1)) dut_z (
    .Clk(clk), .Reset_n(rst_n), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1_z), .ReadData2(rd2_z), .WriteRegisterA(waA), .WriteDataA(wdA),
    .RegWriteA(weA), .WriteRegisterB(waB), .WriteDataB(wdB), .RegWriteB(weB),
    .Clear(clr), .Busy(busy_z), .WriteDropped(drop_z)
  );

  regfile_mp #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b0)) dut_n (
    .Clk(clk), .Reset_n(rst_n), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1_n), .ReadData2(rd2_n), .WriteRegisterA(waA), .WriteDataA(wdA),
    .RegWriteA(weA), .WriteRegisterB(waB), .WriteDataB(wdB), .RegWriteB(weB),
    .Clear(clr), .Busy(busy_n), .WriteDropped(drop_n)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input int k, input logic [AW-1:0] a);
    if (k == 0 && a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!busy_m) begin
      if (weA && waA == a) return wdA;
      if (weB && waB == a) return wdB;
    end
`endif
    return m[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) m[k][i] = '0;
      drop_m[k] = 1'b0;
    end
    busy_m = 1'b0;
    idx_m  = 0;
  endtask

  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      bit skip_a, skip_b;
      skip_a = (k == 0) && (waA == '0);
      skip_b = (k == 0) && (waB == '0);
      if (busy_m) begin
        drop_m[k] = weA || weB;
        m[k][idx_m] = '0;
      end else begin
        drop_m[k] = weA && weB && (waA == waB) && !skip_a;
        if (weB && !skip_b) m[k][waB] = wdB;
        if (weA && !skip_a) m[k][waA] = wdA;
      end
    end
    if (busy_m) begin
      idx_m++;
      if (idx_m == N) begin
        busy_m = 1'b0;
        idx_m  = 0;
      end
    end else if (clr) begin
      busy_m = 1'b1;
      idx_m  = 0;
    end
  endtask

  task automatic check_all();
    chk("z_rd1", rd1_z, exp_rd(0, rr1));
    chk("z_rd2", rd2_z, exp_rd(0, rr2));
    chk("z_busy", W'(busy_z), W'(busy_m));
    chk("z_drop", W'(drop_z), W'(drop_m[0]));
    chk("n_rd1", rd1_n, exp_rd(1, rr1));
    chk("n_rd2", rd2_n, exp_rd(1, rr2));
    chk("n_busy", W'(busy_n), W'(busy_m));
    chk("n_drop", W'(drop_n), W'(drop_m[1]));
  endtask

  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    weA = 1'b0;
    weB = 1'b0;
    clr = 1'b0;
  endtask

  task automatic read_all(input string tag, input bit expect_zero);
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      rr1 = AW'(i);
      rr2 = AW'(N - 1 - i);
      cycle();
      chk(tag, rd1_n, expect_zero ? '0 : W'(i));
    end
  endtask

  typedef struct {
    logic          we_a;
    logic [AW-1:0] wa_a;
    logic [W-1:0]  wd_a;
    logic          we_b;
    logic [AW-1:0] wa_b;
    logic [W-1:0]  wd_b;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [W-1:0]  e1;
    logic [W-1:0]  e2;
    logic          edrop;
  } vec_t;

  vec_t vt [6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rr1 = '0; rr2 = '0; waA = '0; waB = '0; wdA = '0; wdB = '0;
    idle_inputs();
    model_reset();
    #2;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    read_all("reset_rd", 1'b1);

    vt[0] = '{1'b1, 5'd2,  32'd42, 1'b0, 5'd0,  32'd0,  5'd2, 5'd2,  32'd42, 32'd42, 1'b0};
    vt[1] = '{1'b1, 5'd2,  32'd15, 1'b1, 5'd31, 32'd26, 5'd2, 5'd31, 32'd15, 32'd26, 1'b0};
    vt[2] = '{1'b1, 5'd5,  32'd7,  1'b1, 5'd5,  32'd9,  5'd5, 5'd5,  32'd7,  32'd7,  1'b1};
    vt[3] = '{1'b0, 5'd0,  32'd0,  1'b0, 5'd0,  32'd0,  5'd5, 5'd31, 32'd7,  32'd26, 1'b0};
    vt[4] = '{1'b1, 5'd0,  32'd89, 1'b1, 5'd0,  32'd89, 5'd0, 5'd0,  32'd0,  32'd0,  1'b0};
    vt[5] = '{1'b0, 5'd5,  32'd37, 1'b0, 5'd5,  32'd37, 5'd5, 5'd2,  32'd7,  32'd15, 1'b0};

    for (int i = 0; i < 6; i++) begin
      weA = vt[i].we_a; waA = vt[i].wa_a; wdA = vt[i].wd_a;
      weB = vt[i].we_b; waB = vt[i].wa_b; wdB = vt[i].wd_b;
      rr1 = vt[i].r1;   rr2 = vt[i].r2;   clr = 1'b0;
      cycle();
      chk($sformatf("vec%0d_rd1", i), rd1_z, vt[i].e1);
      chk($sformatf("vec%0d_rd2", i), rd2_z, vt[i].e2);
      chk($sformatf("vec%0d_drop", i), W'(drop_z), W'(vt[i].edrop));
      if (i == 4) chk("nozero_r0", rd1_n, 32'd89);
    end

    // Write i to register i, alternating ports, then read everything back.
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      weA = (i % 2 == 0); waA = AW'(i); wdA = W'(i);
      weB = (i % 2 == 1); waB = AW'(i); wdB = W'(i);
      cycle();
    end
    read_all("fill_rd", 1'b0);

    // Clear with a same-cycle write; the write lands and is then swept.
    weA = 1'b1; waA = 5'd7; wdA = 32'h77; clr = 1'b1; rr1 = 5'd7;
    cycle();
    chk("clr_same_cycle_wr", rd1_z, 32'h77);
    idle_inputs();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy_z) break;
      n++;
      if (n == 10) begin
        weA = 1'b1; waA = 5'd3; wdA = 32'hABCD;
      end
      cycle();
      if (n == 10) begin
        chk("mid_sweep_drop", W'(drop_z), 32'd1);
        weA = 1'b0;
      end
    end
    chk("busy_len", W'(n), W'(N));
    read_all("swept_rd", 1'b1);

    // Reset in the middle of a sweep.
    for (int i = 0; i < 8; i++) begin
      weA = 1'b1; waA = AW'($urandom_range(1, N - 1)); wdA = $urandom;
      cycle();
    end
    idle_inputs();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (9) cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", W'(busy_z), 32'd0);
    for (int i = 0; i < N; i++) begin
      rr1 = AW'(i); rr2 = AW'(i);
      #1;
      chk("rst_rd_z", rd1_z, '0);
      chk("rst_rd_n", rd2_n, '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Same-cycle forwarding versus one-cycle write latency.
    weA = 1'b1; waA = 5'd4; wdA = 32'h1234;
    cycle();
    wdA = 32'hDEAD; rr1 = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", rd1_z, 32'hDEAD);
`else
    chk("no_bypass_same_cycle", rd1_z, 32'h1234);
`endif
    cycle();
    chk("after_edge", rd1_z, 32'hDEAD);
    idle_inputs();

    for (int i = 0; i < 400; i++) begin
      weA = 1'($urandom_range(0, 1));
      weB = 1'($urandom_range(0, 1));
      waA = AW'($urandom_range(0, N - 1));
      waB = ($urandom_range(0, 3) == 0) ? waA : AW'($urandom_range(0, N - 1));
      wdA = $urandom;
      wdB = $urandom;
      clr = ($urandom_range(0, 49) == 0);
      rr1 = ($urandom_range(0, 2) == 0) ? waA : AW'($urandom_range(0, N - 1));
      rr2 = ($urandom_range(0, 2) == 0) ? waB : AW'($urandom_range(0, N - 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the 32x32 two-read/one-write CPU register file. Generalised width and depth, with a second write port and asynchronous reset. A sequenced bulk-clear engine is controlled by a Busy handshake. Sits in the CPU datapath between decode (read addresses) and writeback (write ports); register 0 is optionally hardwired to zero.

Parameters:
WIDTH, 32, data word width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
Clk  input  1  clock, positive-edge triggered
Reset_n  input  1  asynchronous active-low reset
ReadRegister1  input  ADDR_W  read port 1 address
ReadRegister2  input  ADDR_W  read port 2 address
ReadData1  output  WIDTH  read port 1 data
ReadData2  output  WIDTH  read port 2 data
WriteRegisterA  input  ADDR_W  write port A address
WriteDataA  input  WIDTH  write port A data
RegWriteA  input  1  write port A enable
WriteRegisterB  input  ADDR_W  write port B address
WriteDataB  input  WIDTH  write port B data
RegWriteB  input  1  write port B enable
Clear  input  1  pulse: start bulk clear sweep
Busy  output  1  high while the clear sweep runs
WriteDropped  output  1  registered; 1 for one cycle when a write was discarded

Behaviour:
- Reset (Reset_n=0, asynchronous): all registers = 0, FSM = IDLE, sweep counter = 0, Busy=0, WriteDropped=0. ReadData1/2 therefore read 0.
- Reads: combinational, zero latency; ReadDataN = reg[ReadRegisterN]. Both ports are fully independent and may use the same address.
- Writes: at posedge Clk, when the FSM is in IDLE:
  - RegWriteA=1 writes reg[WriteRegisterA] = WriteDataA.
  - RegWriteB=1 writes reg[WriteRegisterB] = WriteDataB.
  - Data is visible on reads the cycle after the edge (no bypass unless the optional feature is enabled).
- Write conflict: both enables high with the same address -> port A wins; WriteDataB is discarded and WriteDropped=1 for the next cycle.
- ZERO_REG=1: writes to address 0 are silently ignored (not flagged as dropped); reads of address 0 return 0 regardless of stored state.
- RegWrite low: no register changes, regardless of address or data.
- FSM states:
  - IDLE: Busy=0. Clear=1 -> CLEAR, counter=0.
  - CLEAR: Busy=1. Each cycle, reg[counter]=0 and counter increments. When counter = 2**ADDR_W-1 it clears that register and returns to IDLE. Busy therefore stays high for exactly 2**ADDR_W cycles; the counter wraps to 0.
- During CLEAR:
  - Any asserted write enable is discarded -> WriteDropped=1 next cycle.
  - Clear re-asserted is ignored (no restart).
  - Reads return current contents (partially cleared).
- Clear and write in the same IDLE cycle: the write commits, then the sweep starts next cycle (so the written value is later cleared).
- Reset asserted mid-sweep: immediate return to IDLE, all registers 0.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. If a read address matches an enabled write address in IDLE (and is not a ZERO_REG address 0), ReadDataN shows the incoming write data the same cycle.
  - Port A takes priority over B when both match.
  - No forwarding during CLEAR.
- Undefined: reads show stored contents only (one-cycle write-to-read latency).

Decomposition:
- Package regfile_pkg: FSM state encoding (IDLE, CLEAR) and a default-width constant.
- One natural sub-module, regfile_rdport: combinational read mux with zero-reg masking and optional bypass, instantiated twice.

Test Plan:
- Reset then read all 2**ADDR_W addresses on both ports -> all 0; write 42 to r2 via A -> both ports read 42 next cycle.
- Same-cycle writes: A writes 15 to r2 and B writes 26 to r31 -> r2=15, r31=26, WriteDropped=0. Then A=7 and B=9 both to r5 -> r5=7, WriteDropped=1 for one cycle.
- ZERO_REG=1: write 89 to r0 on A and B -> r0 reads 0, WriteDropped=0. With ZERO_REG=0 -> r0 reads 89.
- RegWriteA=RegWriteB=0 with data 37 to r5 -> r5 unchanged; write i to ri for all i, then read ri on both ports -> i (catches port-stuck and decoder faults).
- Fill all registers, pulse Clear -> Busy high exactly 2**ADDR_W cycles and all registers read 0 after. A write to r3 mid-sweep is discarded with WriteDropped=1. Reset_n low at sweep cycle 10 -> Busy=0 immediately, all registers 0.
- REGFILE_BYPASS_EN defined: A writes 0xDEAD to r4 while ReadRegister1=4 -> ReadData1=0xDEAD in the same cycle. Undefined -> old value until after the edge.
